// File: rtl/hamming_serial_rx_if.sv
// Serial link bundle between the error-injection stage and the Hamming(7,4) receiver.
// The master side drives the serial pair; the slave side returns the decoded word.
interface hamming_serial_rx_if;
  logic       d_in;
  logic       strobe_in;
  logic [3:0] data_out;
  logic       valid_out;
  logic       err_detected;
  logic [2:0] err_pos;
  logic [6:0] codeword_out;
  logic       frame_err;

  modport master (
    output d_in, strobe_in,
    input  data_out, valid_out, err_detected, err_pos, codeword_out, frame_err
  );

  modport slave (
    input  d_in, strobe_in,
    output data_out, valid_out, err_detected, err_pos, codeword_out, frame_err
  );
endinterface

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver: synchronises strobe/data, assembles codewords MSB first,
// corrects single-bit errors and presents the nibble with a one-cycle valid pulse.
module hamming_serial_rx #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_W    = 16
) (
  input logic                 clk,
  input logic                 rst,
  hamming_serial_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECV, DECODE, OUT} state_t;

  state_t          state;
  logic            s1_strobe, s2_strobe, s3_strobe;
  logic            s1_d, s2_d;
  logic [6:0]      sr;
  logic [6:0]      cw;
  logic [2:0]      bit_cnt;
  logic [TO_W-1:0] to_cnt;

  logic [3:0]      data_q;
  logic            valid_q;
  logic            err_q;
  logic [2:0]      pos_q;
  logic [6:0]      cw_q;
  logic            frame_q;

  logic            accept;
  logic            last_bit;
  logic            to_hit;
  logic [2:0]      syn;
  logic [6:0]      fixed;

  assign accept   = ~s2_strobe & s3_strobe;
  assign last_bit = accept && (bit_cnt == 3'd6);
  assign to_hit   = !accept && (bit_cnt != 3'd0) && (to_cnt == TO_W'(TIMEOUT));

  always_comb begin
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    fixed  = cw;
    for (int unsigned i = 0; i < 7; i++) begin
      if (syn == 3'(i + 1)) fixed[i] = ~cw[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s1_strobe <= 1'b0;
      s2_strobe <= 1'b0;
      s3_strobe <= 1'b0;
      s1_d      <= 1'b0;
      s2_d      <= 1'b0;
      sr        <= '0;
      cw        <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
      cw_q      <= '0;
      frame_q   <= 1'b0;
    end else begin
      s1_strobe <= bus.strobe_in;
      s2_strobe <= s1_strobe;
      s3_strobe <= s2_strobe;
      s1_d      <= bus.d_in;
      s2_d      <= s1_d;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;

      // Bit counting runs independently of the decode path so that bits
      // arriving during DECODE/OUT already belong to the next word.
      if (accept) begin
        sr     <= {sr[5:0], s2_d};
        to_cnt <= '0;
        if (last_bit) begin
          bit_cnt <= '0;
          cw      <= {sr[5:0], s2_d};
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (to_hit) begin
        frame_q <= 1'b1;
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else if (bit_cnt != 3'd0) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      unique case (state)
        IDLE:   if (accept) state <= RECV;
        RECV: begin
          if (last_bit)    state <= DECODE;
          else if (to_hit) state <= IDLE;
        end
        DECODE: begin
          data_q  <= {fixed[6], fixed[5], fixed[4], fixed[2]};
          err_q   <= (syn != 3'd0);
          pos_q   <= (syn != 3'd0) ? syn - 3'd1 : 3'd0;
          cw_q    <= cw;
          valid_q <= 1'b1;
          state   <= OUT;
        end
        OUT:    state <= (accept || bit_cnt != 3'd0) ? RECV : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.err_detected = err_q;
  assign bus.err_pos      = pos_q;
  assign bus.codeword_out = cw_q;
  assign bus.frame_err    = frame_q;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Randomised bench for hamming_serial_rx: a queue of expected words built from the
// Hamming(7,4) encoding rules is checked against every valid_out / frame_err pulse.
module tb_hamming_serial_rx;

  localparam int unsigned TIMEOUT = 1000;

  typedef struct packed {
    logic [3:0] data;
    logic       err;
    logic [2:0] pos;
    logic [6:0] cw;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   frames_expected;
  exp_t exp_q[$];

  hamming_serial_rx_if bus ();

  hamming_serial_rx #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c    = '0;
    c[6] = d[3];
    c[5] = d[2];
    c[4] = d[1];
    c[2] = d[0];
    c[0] = c[2] ^ c[4] ^ c[6];
    c[1] = c[2] ^ c[5] ^ c[6];
    c[3] = c[4] ^ c[5] ^ c[6];
    return c;
  endfunction

  // Checker: every valid pulse must match the oldest outstanding word.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_out) begin
        exp_t got;
        got = '{bus.data_out, bus.err_detected, bus.err_pos, bus.codeword_out};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid got data=%b err=%b pos=%0d cw=%b, required no valid",
                   got.data, got.err, got.pos, got.cw);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL word got data=%b err=%b pos=%0d cw=%b, required data=%b err=%b pos=%0d cw=%b",
                     got.data, got.err, got.pos, got.cw, e.data, e.err, e.pos, e.cw);
          end
        end
      end
      if (bus.frame_err) begin
        tests++;
        if (frames_expected == 0) begin
          fails++;
          $display("FAIL unexpected_frame_err got 1, required 0");
        end else begin
          frames_expected--;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int hi, input int lo);
    bus.d_in      = b;
    bus.strobe_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    bus.strobe_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [6:0] c, input int hi, input int lo);
    for (int i = 6; i >= 0; i--) send_bit(c[i], hi, lo);
  endtask

  task automatic queue_word(input logic [3:0] d, input int flip);
    exp_t e;
    e.data = d;
    e.err  = (flip >= 0);
    e.pos  = (flip >= 0) ? 3'(flip) : 3'd0;
    e.cw   = encode(d);
    if (flip >= 0) e.cw[flip] = ~e.cw[flip];
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    tests++;
    if ({bus.data_out, bus.valid_out, bus.err_detected, bus.err_pos, bus.codeword_out, bus.frame_err} !== '0) begin
      fails++;
      $display("FAIL %s got data=%b valid=%b err=%b pos=%0d cw=%b frame=%b, required all 0",
               name, bus.data_out, bus.valid_out, bus.err_detected, bus.err_pos,
               bus.codeword_out, bus.frame_err);
    end
  endtask

  task automatic check_lit(input string name, input logic [6:0] got, input logic [6:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %b, required %b", name, got, req);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    exp_t e;
    tests           = 0;
    fails           = 0;
    frames_expected = 0;
    rst             = 1'b1;
    bus.d_in        = 1'b0;
    bus.strobe_in   = 1'b0;

    check_lit("model_enc_1011", encode(4'b1011), 7'b1010101);
    check_lit("model_enc_0110", encode(4'b0110), 7'b0110011);

    repeat (3) @(posedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Plain word, then the c[4] flip, both pinned to literal expectations.
    e = '{4'b1011, 1'b0, 3'd0, 7'b1010101};
    exp_q.push_back(e);
    send_word(7'b1010101, 3, 3);
    drain("t1");
    e = '{4'b1011, 1'b1, 3'd4, 7'b1000101};
    exp_q.push_back(e);
    send_word(7'b1000101, 3, 3);
    drain("t2");

    for (int i = 0; i < 7; i++) begin
      logic [6:0] c;
      c    = encode(4'b0110);
      c[i] = ~c[i];
      queue_word(4'b0110, i);
      send_word(c, 4, 3);
    end
    drain("t3");

    // Partial word abandoned on timeout, then a clean word.
    frames_expected = 1;
    send_bit(1'b1, 3, 3);
    send_bit(1'b0, 3, 3);
    send_bit(1'b1, 3, 3);
    repeat (TIMEOUT + 5) @(posedge clk); #1;
    tests++;
    if (frames_expected != 0) begin
      fails++;
      $display("FAIL t4_frame_err got %0d pulses missing, required 0", frames_expected);
      frames_expected = 0;
    end
    queue_word(4'b1011, -1);
    send_word(7'b1010101, 3, 3);
    drain("t4");

    // Reset in the middle of a word.
    send_bit(1'b0, 3, 3);
    send_bit(1'b1, 3, 3);
    send_bit(1'b1, 3, 3);
    send_bit(1'b0, 3, 3);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check_zero("t5_in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    queue_word(4'b1011, -1);
    send_word(7'b1010101, 3, 3);
    drain("t5");

    // Back-to-back words at minimum strobe width, random data and error position.
    for (int w = 0; w < 30; w++) begin
      logic [3:0] d;
      int         flip;
      logic [6:0] c;
      d    = 4'($urandom_range(0, 15));
      flip = int'($urandom_range(0, 7)) - 1;
      c    = encode(d);
      if (flip >= 0) c[flip] = ~c[flip];
      queue_word(d, flip);
      send_word(c, 3, 3);
    end
    drain("t6");

    // Random strobe widths.
    for (int w = 0; w < 15; w++) begin
      logic [3:0] d;
      int         flip;
      logic [6:0] c;
      d    = 4'($urandom_range(0, 15));
      flip = int'($urandom_range(0, 7)) - 1;
      c    = encode(d);
      if (flip >= 0) c[flip] = ~c[flip];
      queue_word(d, flip);
      for (int i = 6; i >= 0; i--)
        send_bit(c[i], int'($urandom_range(3, 6)), int'($urandom_range(3, 6)));
    end
    drain("t7");

    repeat (5) @(posedge clk); #1;
    tests++;
    if (frames_expected != 0) begin
      fails++;
      $display("FAIL final_frames got %0d outstanding, required 0", frames_expected);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hamming_serial_rx.md
Name: hamming_serial_rx

Overview:
- Serial receiver and single-error corrector for the Hamming(7,4) link.
- Sits directly downstream of the serial error-injection stage and consumes its d_out/strobe_out pair as d_in/strobe_in.
- Synchronises the strobe/data pair into the system clock and assembles 7-bit codewords, MSB (c[6]) first.
- Computes the syndrome, corrects any single-bit error, and presents the 4-bit data word with a one-cycle valid pulse.

Parameters:
- TIMEOUT, 1000: clocks allowed between accepted bits while a word is partially received; on expiry the partial word is discarded.
- TO_W, 16: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- d_in  input  1  serial codeword bit, asynchronous to clk.
- strobe_in  input  1  bit strobe, asynchronous to clk. Each high phase and each low phase is at least 3 clk periods.
- data_out  output  4  corrected data nibble {d3,d2,d1,d0}.
- valid_out  output  1  one-cycle pulse; data_out, err_detected and err_pos are valid while it is high.
- err_detected  output  1  syndrome was nonzero for this word.
- err_pos  output  3  index i of the flipped bit c[i]; 0 when no error.
- codeword_out  output  7  raw received codeword, before correction.
- frame_err  output  1  one-cycle pulse when a partial word is dropped on timeout.

Behaviour:
- Reset values: all outputs 0; bit_cnt 0; shift register 0; timeout counter 0; FSM in IDLE. Sync flops are cleared to 0.
- Synchronisation: strobe_in and d_in each pass through two flops (s1, s2); s3 delays the strobe by one more clock.
- Bit acceptance: a bit is accepted on a detected falling edge (s2_strobe=0, s3_strobe=1). The synchronised d_in is shifted in on that edge: sr <= {sr[5:0], d_sync}. The first received bit therefore ends in c[6].
- Codeword layout (Hamming position p = i+1):
  - parity: c[0]=p1, c[1]=p2, c[3]=p4
  - data: d3=c[6], d2=c[5], d1=c[4], d0=c[2]
- Syndrome:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - S = {s4,s2,s1}
  - S≠0: invert c[S-1], set err_detected=1, err_pos=S-1.
  - S=0: no correction, err_detected=0, err_pos=0.
- FSM:
  - IDLE (bit_cnt=0): on an accepted bit go to RECV with bit_cnt=1.
  - RECV: each accepted bit increments bit_cnt. On the 7th bit, copy sr into the decode register cw, reset bit_cnt to 0, and go to DECODE.
  - DECODE (one clock): compute syndrome, apply correction, register the outputs. Go to OUT.
  - OUT (one clock): valid_out=1. Go to IDLE, or to RECV if a bit was accepted in this clock.
- Latency: valid_out is high exactly one clock, on the second clock after the edge that shifted in the 7th bit.
- Output hold: data_out, err_detected, err_pos and codeword_out hold their values until the next word's DECODE.
- Overlap: the shift register is independent of cw. A bit accepted during DECODE or OUT goes into the next word and is never lost.
- Timeout:
  - While bit_cnt≠0, the counter increments each clock and clears on every accepted bit.
  - When the counter reaches TIMEOUT, frame_err pulses for one clock, bit_cnt and the counter clear, the FSM returns to IDLE, and no valid_out is produced.
  - The counter is held at 0 in IDLE.
- Reset mid-word: the partial word is discarded and no valid_out or frame_err is produced.
- Double-bit errors are miscorrected, as inherent to Hamming(7,4). No detection of them is required.

Test Plan:
1. Send codeword 7'b1010101 (data 1011) with no error -> one valid_out; data_out=4'b1011, err_detected=0, err_pos=0, codeword_out=7'b1010101.
2. Same word with c[4] flipped (7'b1000101) -> S=3'b101; data_out=4'b1011, err_detected=1, err_pos=3'd4.
3. Sweep the single-bit error over each of c[0]..c[6] on data 4'b0110 -> data_out=4'b0110 every time; err_pos equals the flipped index.
4. Send 3 bits, then idle the strobe for TIMEOUT+5 clocks -> frame_err pulses once and no valid_out. A following full word 1010101 then decodes to 1011.
5. Assert rst after 4 bits, release it, then send a full word -> no output for the partial word; the new word decodes correctly; all outputs read 0 during reset.
6. Send back-to-back words at the minimum strobe width (3 clk high / 3 clk low) -> one valid_out per word, no bits dropped, correct data for each.
